reorder_buffer_mc: RTL and testbench
====================================

// Module: reorder_buffer_mc
// PURPOSE
//  Parametrised reorder buffer, successor to the single-commit ROB. Circular queue between the instruction
//  unit and the RS/LSB/RF. Accepts WB_PORTS result broadcasts per cycle and retires up to COMMIT_W entries
//  in order per cycle. Resolves branch mispredicts and JALR targets at the head.
// PARAMETERS
//  DEPTH     16  entries; power of 2, >=4
//  IDX_W     4   $clog2(DEPTH); width of every entry index
//  WB_PORTS  2   writeback (CDB) input ports; 1..4
//  COMMIT_W  2   max retirements per cycle; 1 or 2
// PORTS
//  clk_in        in   1            clock
//  rst_in        in   1            synchronous reset, active-high
//  rdy_in        in   1            low = freeze all state
//  inst_req      in   1            issue one entry at tail this cycle
//  inst_kind     in   2            0 REG (alu/load), 1 STORE, 2 BRANCH, 3 JALR
//  inst_rd/imm/pc in  5/32/32      dest reg, branch offset, instruction pc
//  inst_pred     in   1            predicted taken
//  wb_valid      in   WB_PORTS     per-port result strobe
//  wb_idx        in   WB_PORTS*IDX_W  target entry index (port k at [k*IDX_W +: IDX_W])
//  wb_val        in   WB_PORTS*32  result; bit0 = taken for BRANCH
//  mem_busy      in   1            memory unit busy; blocks STORE commit
//  full_out      out  1            registered; no free entry next cycle
//  head_out/tail_out out IDX_W     current head/tail index
//  cm_valid      out  COMMIT_W     per-slot retire strobe
//  cm_rd         out  COMMIT_W*5   RF write reg (0 = no write)
//  cm_val        out  COMMIT_W*32  RF write value
//  cm_idx        out  COMMIT_W*IDX_W  retired entry index (RF tag clear)
//  clear_out     out  1            one-cycle flush pulse
//  clear_pc      out  32           redirect pc, valid with clear_out
//  jalr_ready/jalr_addr out 1/32   JALR retired; fetch resumes at jalr_addr
//  br_ready/br_taken/br_correct out 1 each   branch retired, outcome, prediction hit
// BEHAVIOUR
//  Reset (rst_in at posedge): all entries invalid; head=tail=count=0; every output 0. Same on the edge after clear_out=1.
//  rdy_in=0: no state or output changes; consumers qualify outputs with rdy_in.
//  Issue: inst_req writes tail (valid=1, ready=0); tail<=tail+1 mod DEPTH. inst_req while full_out=1 is dropped.
//  Writeback: wb_valid[k] sets result/ready of wb_idx[k]. Writes to invalid entries are ignored.
//   Same index on two ports: lowest port wins.
//  Commit eligibility is evaluated on registered state, so an entry written back at edge N can retire at edge N+1.
//   cm_* are registered and visible for the cycle after that edge.
//  Slot0 (head) retires if valid && ready, except STORE with mem_busy=1, which stalls.
//  Slot1 (head+1, COMMIT_W=2 only) retires iff slot0 retires, both are REG kind, and head+1 is valid && ready.
//  Retired REG: cm_rd=rd, cm_val=result. STORE: cm_rd=0.
//  JALR: cm_rd=rd, cm_val=pc+4, jalr_ready=1, jalr_addr=result.
//  BRANCH: br_ready=1, br_taken=result[0], br_correct=(pred==result[0]).
//   On mismatch: clear_out=1, clear_pc = taken ? pc+imm : pc+4 (mod 2^32).
//   While clear_out=1: no issue or commit is accepted; the next edge flushes.
//  Strobes (cm_valid, jalr_ready, br_ready, clear_out) are one-cycle pulses, 0 when nothing retires.
//  count <= count + issue - retired. full_out <= (count_next == DEPTH). Head/tail wrap mod DEPTH.
//  Empty (count=0): nothing retires, even if head has stale ready.
// CONFIGURATION
//  ROB_QUERY_EN defined: adds 2 combinational query ports per source operand, with inputs q_idx[1:0] (IDX_W each)
//   and outputs q_ready[1:0] and q_val[1:0] (32 each).
//   Each returns the entry ready bit and result, with same-cycle writeback forwarding: the lowest matching wb port overrides.
//  ROB_QUERY_EN undefined: the query ports are absent, and there is no added logic.
// TESTING
//  Reset then 16 issues, no wb -> full_out=1 after 16th; 17th inst_req dropped; tail=0.
//  Issue REG x1,x2 at idx0,1; wb port0 idx1=7 then port1 idx0=5 -> single cycle cm_valid=2'b11, cm_rd={2,1}, cm_val={7,5}.
//  BRANCH pred=1 pc=0x100 imm=0x20, wb val=0 -> br_correct=0, clear_out=1, clear_pc=0x104; next cycle count=0, head=tail=0.
//  STORE at head ready with mem_busy=1 for 3 cycles -> no cm_valid; retires cycle after mem_busy falls, cm_rd=0.
//  JALR rd=1 pc=0x200, wb 0x400 -> cm_rd=1, cm_val=0x204, jalr_ready=1, jalr_addr=0x400; slot1 REG ready does not retire same cycle.
//  Wrap: 40 issue/retire pairs at DEPTH=16 -> in-order cm_idx 0..15,0..; rst_in mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/reorder_buffer_mc_if.sv
// reorder_buffer_mc_if
//  Bundles the issue, writeback, commit and redirect signals of the reorder buffer.
//  slave  : reorder buffer side (takes issue/writeback, drives commit/redirect/status)
//  master : instruction unit / execution side
//  Issue    : inst_req, inst_kind, inst_rd, inst_imm, inst_pc, inst_pred
//  Wb       : wb_valid, wb_idx, wb_val (port k at [k*IDX_W +: IDX_W] / [k*32 +: 32])
//  Control  : rdy_in (low freezes the buffer), mem_busy (stalls STORE commit)
//  Status   : full_out, head_out, tail_out
//  Commit   : cm_valid, cm_rd, cm_val, cm_idx (slot j in field j)
//  Redirect : clear_out, clear_pc, jalr_ready, jalr_addr, br_ready, br_taken, br_correct
//  ROB_QUERY_EN adds q_idx (in) and q_ready/q_val (out), two operand queries.
interface reorder_buffer_mc_if #(
   parameter int DEPTH    = 16,
   parameter int IDX_W    = 4,
   parameter int WB_PORTS = 2,
   parameter int COMMIT_W = 2
);
   logic                         rdy_in;
   logic                         inst_req;
   logic [1:0]                   inst_kind;
   logic [4:0]                   inst_rd;
   logic [31:0]                  inst_imm;
   logic [31:0]                  inst_pc;
   logic                         inst_pred;
   logic [WB_PORTS-1:0]          wb_valid;
   logic [WB_PORTS*IDX_W-1:0]    wb_idx;
   logic [WB_PORTS*32-1:0]       wb_val;
   logic                         mem_busy;
   logic                         full_out;
   logic [IDX_W-1:0]             head_out;
   logic [IDX_W-1:0]             tail_out;
   logic [COMMIT_W-1:0]          cm_valid;
   logic [COMMIT_W*5-1:0]        cm_rd;
   logic [COMMIT_W*32-1:0]       cm_val;
   logic [COMMIT_W*IDX_W-1:0]    cm_idx;
   logic                         clear_out;
   logic [31:0]                  clear_pc;
   logic                         jalr_ready;
   logic [31:0]                  jalr_addr;
   logic                         br_ready;
   logic                         br_taken;
   logic                         br_correct;
`ifdef ROB_QUERY_EN
   logic [1:0][IDX_W-1:0]        q_idx;
   logic [1:0]                   q_ready;
   logic [1:0][31:0]             q_val;

   modport slave (
      input  rdy_in, inst_req, inst_kind, inst_rd, inst_imm, inst_pc, inst_pred,
             wb_valid, wb_idx, wb_val, mem_busy, q_idx,
      output full_out, head_out, tail_out, cm_valid, cm_rd, cm_val, cm_idx,
             clear_out, clear_pc, jalr_ready, jalr_addr, br_ready, br_taken, br_correct,
             q_ready, q_val
   );
   modport master (
      output rdy_in, inst_req, inst_kind, inst_rd, inst_imm, inst_pc, inst_pred,
             wb_valid, wb_idx, wb_val, mem_busy, q_idx,
      input  full_out, head_out, tail_out, cm_valid, cm_rd, cm_val, cm_idx,
             clear_out, clear_pc, jalr_ready, jalr_addr, br_ready, br_taken, br_correct,
             q_ready, q_val
   );
`else
   modport slave (
      input  rdy_in, inst_req, inst_kind, inst_rd, inst_imm, inst_pc, inst_pred,
             wb_valid, wb_idx, wb_val, mem_busy,
      output full_out, head_out, tail_out, cm_valid, cm_rd, cm_val, cm_idx,
             clear_out, clear_pc, jalr_ready, jalr_addr, br_ready, br_taken, br_correct
   );
   modport master (
      output rdy_in, inst_req, inst_kind, inst_rd, inst_imm, inst_pc, inst_pred,
             wb_valid, wb_idx, wb_val, mem_busy,
      input  full_out, head_out, tail_out, cm_valid, cm_rd, cm_val, cm_idx,
             clear_out, clear_pc, jalr_ready, jalr_addr, br_ready, br_taken, br_correct
   );
`endif
endinterface

// File: rtl/reorder_buffer_mc.sv
// reorder_buffer_mc
//  Circular reorder buffer with WB_PORTS writeback ports and up to COMMIT_W in-order
//  retirements per cycle. Branch mispredicts and JALR targets resolve at the head.
//  Ports:
//   clk_in : clock
//   rst_in : synchronous reset, active-high
//   rob    : reorder_buffer_mc_if.slave (issue, writeback, commit, redirect, status)
//  Optional: define ROB_QUERY_EN for two combinational operand-query ports with
//  same-cycle writeback forwarding.
module reorder_buffer_mc #(
   parameter int DEPTH    = 16,
   parameter int IDX_W    = 4,
   parameter int WB_PORTS = 2,
   parameter int COMMIT_W = 2
) (
   input  logic               clk_in,
   input  logic               rst_in,
   reorder_buffer_mc_if.slave rob
);
   localparam logic [1:0] KIND_REG    = 2'd0;
   localparam logic [1:0] KIND_STORE  = 2'd1;
   localparam logic [1:0] KIND_BRANCH = 2'd2;
   localparam logic [1:0] KIND_JALR   = 2'd3;
   localparam int         CNT_W       = IDX_W + 1;

   logic [DEPTH-1:0] e_valid;
   logic [DEPTH-1:0] e_ready;
   logic [DEPTH-1:0] e_pred;
   logic [1:0]       e_kind   [DEPTH];
   logic [4:0]       e_rd     [DEPTH];
   logic [31:0]      e_imm    [DEPTH];
   logic [31:0]      e_pc     [DEPTH];
   logic [31:0]      e_result [DEPTH];

   logic [IDX_W-1:0] head;
   logic [IDX_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             full_q;

   // Commit slots are always held two wide; only COMMIT_W of them reach the ports.
   logic [1:0]       cm_valid_d, cm_valid_q;
   logic [9:0]       cm_rd_d, cm_rd_q;
   logic [63:0]      cm_val_d, cm_val_q;
   logic [2*IDX_W-1:0] cm_idx_d, cm_idx_q;
   logic             clr_d, clr_q;
   logic [31:0]      clr_pc_d, clr_pc_q;
   logic             jr_d, jr_q;
   logic [31:0]      ja_d, ja_q;
   logic             br_d, br_q;
   logic             brt_d, brt_q;
   logic             brc_d, brc_q;

   logic [IDX_W-1:0] head1;
   logic             do_issue;
   logic             retire0;
   logic             retire1;
   logic [CNT_W-1:0] count_next;

   assign head1    = head + IDX_W'(1);
   assign do_issue = rob.inst_req && !full_q;

   // Eligibility looks only at registered entry state, so a result written back at
   // one edge retires at the next.
   always_comb begin
      retire0 = (count != '0) && e_valid[head] && e_ready[head] &&
                !((e_kind[head] == KIND_STORE) && rob.mem_busy);
      retire1 = 1'b0;
      if (COMMIT_W == 2) begin
         retire1 = retire0 && (count > CNT_W'(1)) &&
                   (e_kind[head] == KIND_REG) && (e_kind[head1] == KIND_REG) &&
                   e_valid[head1] && e_ready[head1];
      end
   end

   assign count_next = count + CNT_W'(do_issue) - CNT_W'(retire0) - CNT_W'(retire1);

   always_comb begin
      cm_valid_d = '0;
      cm_rd_d    = '0;
      cm_val_d   = '0;
      cm_idx_d   = '0;
      clr_d      = 1'b0;
      clr_pc_d   = '0;
      jr_d       = 1'b0;
      ja_d       = '0;
      br_d       = 1'b0;
      brt_d      = 1'b0;
      brc_d      = 1'b0;
      if (retire0) begin
         cm_valid_d[0]          = 1'b1;
         cm_idx_d[0 +: IDX_W]   = head;
         case (e_kind[head])
            KIND_REG: begin
               cm_rd_d[4:0]   = e_rd[head];
               cm_val_d[31:0] = e_result[head];
            end
            KIND_STORE: begin
               cm_val_d[31:0] = e_result[head];
            end
            KIND_JALR: begin
               cm_rd_d[4:0]   = e_rd[head];
               cm_val_d[31:0] = e_pc[head] + 32'd4;
               jr_d           = 1'b1;
               ja_d           = e_result[head];
            end
            default: begin
               br_d  = 1'b1;
               brt_d = e_result[head][0];
               brc_d = (e_pred[head] == e_result[head][0]);
               if (e_pred[head] != e_result[head][0]) begin
                  clr_d    = 1'b1;
                  clr_pc_d = e_result[head][0] ? (e_pc[head] + e_imm[head])
                                               : (e_pc[head] + 32'd4);
               end
            end
         endcase
      end
      if (retire1) begin
         cm_valid_d[1]            = 1'b1;
         cm_idx_d[IDX_W +: IDX_W] = head1;
         cm_rd_d[9:5]             = e_rd[head1];
         cm_val_d[63:32]          = e_result[head1];
      end
   end

   always_ff @(posedge clk_in) begin
      // The edge after a flush pulse behaves exactly like reset.
      if (rst_in || (rob.rdy_in && clr_q)) begin
         for (int i = 0; i < DEPTH; i++) begin
            e_valid[i] <= 1'b0;
            e_ready[i] <= 1'b0;
         end
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         full_q     <= 1'b0;
         cm_valid_q <= '0;
         cm_rd_q    <= '0;
         cm_val_q   <= '0;
         cm_idx_q   <= '0;
         clr_q      <= 1'b0;
         clr_pc_q   <= '0;
         jr_q       <= 1'b0;
         ja_q       <= '0;
         br_q       <= 1'b0;
         brt_q      <= 1'b0;
         brc_q      <= 1'b0;
      end else if (rob.rdy_in) begin
         // Descending loop: the lowest port's write is the last one scheduled and wins.
         for (int k = WB_PORTS - 1; k >= 0; k--) begin
            if (rob.wb_valid[k] && e_valid[rob.wb_idx[k*IDX_W +: IDX_W]]) begin
               e_ready[rob.wb_idx[k*IDX_W +: IDX_W]]  <= 1'b1;
               e_result[rob.wb_idx[k*IDX_W +: IDX_W]] <= rob.wb_val[k*32 +: 32];
            end
         end
         if (do_issue) begin
            e_valid[tail] <= 1'b1;
            e_ready[tail] <= 1'b0;
            e_kind[tail]  <= rob.inst_kind;
            e_rd[tail]    <= rob.inst_rd;
            e_imm[tail]   <= rob.inst_imm;
            e_pc[tail]    <= rob.inst_pc;
            e_pred[tail]  <= rob.inst_pred;
            tail          <= tail + IDX_W'(1);
         end
         // Retired entries also drop ready so an empty slot never looks committable.
         if (retire0) begin
            e_valid[head] <= 1'b0;
            e_ready[head] <= 1'b0;
         end
         if (retire1) begin
            e_valid[head1] <= 1'b0;
            e_ready[head1] <= 1'b0;
         end
         head       <= head + IDX_W'(retire0) + IDX_W'(retire1);
         count      <= count_next;
         full_q     <= (count_next == CNT_W'(DEPTH));
         cm_valid_q <= cm_valid_d;
         cm_rd_q    <= cm_rd_d;
         cm_val_q   <= cm_val_d;
         cm_idx_q   <= cm_idx_d;
         clr_q      <= clr_d;
         clr_pc_q   <= clr_pc_d;
         jr_q       <= jr_d;
         ja_q       <= ja_d;
         br_q       <= br_d;
         brt_q      <= brt_d;
         brc_q      <= brc_d;
      end
   end

   assign rob.full_out   = full_q;
   assign rob.head_out   = head;
   assign rob.tail_out   = tail;
   assign rob.cm_valid   = cm_valid_q[COMMIT_W-1:0];
   assign rob.cm_rd      = cm_rd_q[COMMIT_W*5-1:0];
   assign rob.cm_val     = cm_val_q[COMMIT_W*32-1:0];
   assign rob.cm_idx     = cm_idx_q[COMMIT_W*IDX_W-1:0];
   assign rob.clear_out  = clr_q;
   assign rob.clear_pc   = clr_pc_q;
   assign rob.jalr_ready = jr_q;
   assign rob.jalr_addr  = ja_q;
   assign rob.br_ready   = br_q;
   assign rob.br_taken   = brt_q;
   assign rob.br_correct = brc_q;

`ifdef ROB_QUERY_EN
   logic [1:0]        q_ready_c;
   logic [1:0][31:0]  q_val_c;

   // Operand lookup with bypass of results arriving this cycle; lowest port overrides.
   always_comb begin
      q_ready_c = '0;
      q_val_c   = '0;
      for (int q = 0; q < 2; q++) begin
         q_ready_c[q] = e_ready[rob.q_idx[q]];
         q_val_c[q]   = e_result[rob.q_idx[q]];
         for (int k = WB_PORTS - 1; k >= 0; k--) begin
            if (rob.wb_valid[k] && (rob.wb_idx[k*IDX_W +: IDX_W] == rob.q_idx[q]) &&
                e_valid[rob.q_idx[q]]) begin
               q_ready_c[q] = 1'b1;
               q_val_c[q]   = rob.wb_val[k*32 +: 32];
            end
         end
      end
   end

   assign rob.q_ready = q_ready_c;
   assign rob.q_val   = q_val_c;
`endif
endmodule

// File: tb/tb_reorder_buffer_mc.sv
// tb_reorder_buffer_mc
//  Directed bench for reorder_buffer_mc (DEPTH 16, 2 wb ports, 2 commit slots).
//  A table of per-cycle {inputs, expected outputs} rows covers dual commit, port
//  priority, branch outcomes, store stall, JALR and freeze; hand sequences cover
//  filling the buffer, index wrap-around and a mid-stream reset.
module tb_reorder_buffer_mc;
   localparam logic [1:0] K_REG = 2'd0, K_STORE = 2'd1, K_BRANCH = 2'd2, K_JALR = 2'd3;

   typedef struct packed {
      logic [1:0]  cmv;
      logic [9:0]  cmrd;
      logic [63:0] cmval;
      logic [7:0]  cmidx;
      logic        clr;
      logic [31:0] clrpc;
      logic        br;
      logic        brt;
      logic        brc;
      logic        jr;
      logic [31:0] ja;
      logic [3:0]  head;
      logic [3:0]  tail;
      logic        full;
   } out_t;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        req;
      logic [1:0]  kind;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        pred;
      logic [1:0]  wbv;
      logic [3:0]  wbi0;
      logic [3:0]  wbi1;
      logic [31:0] wbd0;
      logic [31:0] wbd1;
      logic        busy;
      out_t        exp;
   } vec_t;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   int   n_vec  = 0;
   int   n_bad  = 0;
   vec_t tbl[$];

   always #5 clk_in = ~clk_in;

   reorder_buffer_mc_if #(.DEPTH(16), .IDX_W(4), .WB_PORTS(2), .COMMIT_W(2)) rob_bus ();

   reorder_buffer_mc #(.DEPTH(16), .IDX_W(4), .WB_PORTS(2), .COMMIT_W(2)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rob    (rob_bus)
   );

   function automatic vec_t nop();
      vec_t t;
      t = '{default: '0};
      t.rdy = 1'b1;
      return t;
   endfunction

   function automatic vec_t iss(input logic [1:0] k, input logic [4:0] rd, input logic [31:0] pc,
                                input logic [31:0] imm, input logic pred);
      vec_t t;
      t = nop();
      t.req = 1'b1; t.kind = k; t.rd = rd; t.pc = pc; t.imm = imm; t.pred = pred;
      return t;
   endfunction

   task automatic add(input vec_t t, input int h, input int tl);
      t.exp.head = 4'(h);
      t.exp.tail = 4'(tl);
      tbl.push_back(t);
   endtask

   task automatic drive(input vec_t t);
      rst_in            = t.rst;
      rob_bus.rdy_in    = t.rdy;
      rob_bus.inst_req  = t.req;
      rob_bus.inst_kind = t.kind;
      rob_bus.inst_rd   = t.rd;
      rob_bus.inst_imm  = t.imm;
      rob_bus.inst_pc   = t.pc;
      rob_bus.inst_pred = t.pred;
      rob_bus.wb_valid  = t.wbv;
      rob_bus.wb_idx    = {t.wbi1, t.wbi0};
      rob_bus.wb_val    = {t.wbd1, t.wbd0};
      rob_bus.mem_busy  = t.busy;
   endtask

   function automatic out_t sample();
      out_t o;
      o.cmv   = rob_bus.cm_valid;
      o.cmrd  = rob_bus.cm_rd;
      o.cmval = rob_bus.cm_val;
      o.cmidx = rob_bus.cm_idx;
      o.clr   = rob_bus.clear_out;
      o.clrpc = rob_bus.clear_pc;
      o.br    = rob_bus.br_ready;
      o.brt   = rob_bus.br_taken;
      o.brc   = rob_bus.br_correct;
      o.jr    = rob_bus.jalr_ready;
      o.ja    = rob_bus.jalr_addr;
      o.head  = rob_bus.head_out;
      o.tail  = rob_bus.tail_out;
      o.full  = rob_bus.full_out;
      return o;
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t t;
      out_t got;

      drive(nop());
      rst_in = 1'b1;
`ifdef ROB_QUERY_EN
      rob_bus.q_idx = '0;
`endif
      step();
      step();

      // ---------------- table ----------------
      t = nop(); t.rst = 1'b1; add(t, 0, 0);
      add(iss(K_REG, 1, 32'h0, 0, 0), 0, 1);
      add(iss(K_REG, 2, 32'h4, 0, 0), 0, 2);
      t = nop(); t.wbv = 2'b01; t.wbi0 = 1; t.wbd0 = 7; add(t, 0, 2);
      t = nop(); t.wbv = 2'b10; t.wbi1 = 0; t.wbd1 = 5; add(t, 0, 2);
      t = nop(); t.exp.cmv = 2'b11; t.exp.cmrd = {5'd2, 5'd1}; t.exp.cmval = {32'd7, 32'd5};
      t.exp.cmidx = {4'd1, 4'd0}; add(t, 2, 2);
      add(iss(K_REG, 3, 32'h8, 0, 0), 2, 3);
      t = nop(); t.wbv = 2'b11; t.wbi0 = 2; t.wbd0 = 32'h11; t.wbi1 = 2; t.wbd1 = 32'h22; add(t, 2, 3);
      t = nop(); t.exp.cmv = 2'b01; t.exp.cmrd = 10'd3; t.exp.cmval = 64'h11; t.exp.cmidx = 8'h02;
      add(t, 3, 3);
      add(iss(K_BRANCH, 0, 32'h100, 32'h20, 1), 3, 4);
      t = nop(); t.wbv = 2'b01; t.wbi0 = 3; t.wbd0 = 0; add(t, 3, 4);
      t = nop(); t.exp.cmv = 2'b01; t.exp.cmidx = 8'h03; t.exp.br = 1; t.exp.brt = 0; t.exp.brc = 0;
      t.exp.clr = 1; t.exp.clrpc = 32'h104; add(t, 4, 4);
      add(iss(K_REG, 6, 32'h0, 0, 0), 0, 0);
      add(iss(K_BRANCH, 0, 32'h300, 32'h8, 0), 0, 1);
      t = nop(); t.wbv = 2'b01; t.wbi0 = 0; t.wbd0 = 0; add(t, 0, 1);
      t = nop(); t.exp.cmv = 2'b01; t.exp.cmidx = 8'h00; t.exp.br = 1; t.exp.brc = 1; add(t, 1, 1);
      add(iss(K_BRANCH, 0, 32'h400, 32'h40, 0), 1, 2);
      t = nop(); t.wbv = 2'b10; t.wbi1 = 1; t.wbd1 = 1; add(t, 1, 2);
      t = nop(); t.exp.cmv = 2'b01; t.exp.cmidx = 8'h01; t.exp.br = 1; t.exp.brt = 1; t.exp.brc = 0;
      t.exp.clr = 1; t.exp.clrpc = 32'h440; add(t, 2, 2);
      add(nop(), 0, 0);
      add(iss(K_STORE, 9, 32'h500, 0, 0), 0, 1);
      t = nop(); t.wbv = 2'b01; t.wbi0 = 0; t.wbd0 = 32'hAA; t.busy = 1; add(t, 0, 1);
      for (int i = 0; i < 3; i++) begin
         t = nop(); t.busy = 1; add(t, 0, 1);
      end
      t = nop(); t.exp.cmv = 2'b01; t.exp.cmrd = 10'd0; t.exp.cmval = 64'hAA; t.exp.cmidx = 8'h00;
      add(t, 1, 1);
      add(iss(K_JALR, 1, 32'h200, 0, 0), 1, 2);
      add(iss(K_REG, 5, 32'h204, 0, 0), 1, 3);
      t = nop(); t.wbv = 2'b11; t.wbi0 = 1; t.wbd0 = 32'h400; t.wbi1 = 2; t.wbd1 = 32'h55; add(t, 1, 3);
      t = nop(); t.exp.cmv = 2'b01; t.exp.cmrd = 10'd1; t.exp.cmval = 64'h204; t.exp.cmidx = 8'h01;
      t.exp.jr = 1; t.exp.ja = 32'h400; add(t, 2, 3);
      t = nop(); t.exp.cmv = 2'b01; t.exp.cmrd = 10'd5; t.exp.cmval = 64'h55; t.exp.cmidx = 8'h02;
      add(t, 3, 3);
      add(iss(K_REG, 7, 32'h208, 0, 0), 3, 4);
      t = nop(); t.wbv = 2'b01; t.wbi0 = 3; t.wbd0 = 32'h77; add(t, 3, 4);
      t = nop(); t.exp.cmv = 2'b01; t.exp.cmrd = 10'd7; t.exp.cmval = 64'h77; t.exp.cmidx = 8'h03;
      add(t, 4, 4);
      t = iss(K_REG, 8, 32'h0, 0, 0); t.rdy = 0; t.wbv = 2'b01; t.wbi0 = 4; t.wbd0 = 1;
      t.exp = tbl[tbl.size() - 1].exp; tbl.push_back(t);
      add(nop(), 4, 4);
      t = nop(); t.wbv = 2'b01; t.wbi0 = 4; t.wbd0 = 32'h99; add(t, 4, 4);
      add(nop(), 4, 4);
      add(iss(K_REG, 4, 32'h20C, 0, 0), 4, 5);
      add(nop(), 4, 5);
      t = nop(); t.wbv = 2'b01; t.wbi0 = 4; t.wbd0 = 32'h44; add(t, 4, 5);
      t = nop(); t.exp.cmv = 2'b01; t.exp.cmrd = 10'd4; t.exp.cmval = 64'h44; t.exp.cmidx = 8'h04;
      add(t, 5, 5);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         step();
         got = sample();
         chk($sformatf("vec%0d", i), 128'(got), 128'(tbl[i].exp));
      end

      // ---------------- fill to full, 17th issue dropped ----------------
      t = nop(); t.rst = 1; drive(t); step();
      for (int i = 0; i < 17; i++) begin
         drive(iss(K_REG, 5'(i + 1), 32'(i * 4), 0, 0));
         step();
         chk($sformatf("fill%0d", i), {rob_bus.full_out, rob_bus.head_out, rob_bus.tail_out},
             {(i >= 15) ? 1'b1 : 1'b0, 4'd0, 4'((i >= 15) ? 0 : i + 1)});
      end

      // ---------------- wrap: 40 issue/retire pairs ----------------
      t = nop(); t.rst = 1; drive(t); step();
      for (int i = 0; i < 42; i++) begin
         t = (i < 40) ? iss(K_REG, 5'((i % 31) + 1), 32'(i * 4), 0, 0) : nop();
         if (i >= 1 && i <= 40) begin
            t.wbv = 2'b01; t.wbi0 = 4'((i - 1) % 16); t.wbd0 = 32'((i - 1) * 3 + 1);
         end
         drive(t);
         step();
         if (i >= 2)
            chk($sformatf("wrap%0d", i),
                {rob_bus.cm_valid, rob_bus.cm_idx, rob_bus.cm_rd, rob_bus.cm_val},
                {2'b01, 4'd0, 4'((i - 2) % 16), 5'd0, 5'(((i - 2) % 31) + 1), 32'd0, 32'((i - 2) * 3 + 1)});
         else
            chk($sformatf("wrap%0d", i), 128'(rob_bus.cm_valid), 128'(0));
      end
      chk("wrap_end", {rob_bus.head_out, rob_bus.tail_out}, {4'd8, 4'd8});

      // ---------------- reset mid-stream ----------------
      drive(iss(K_REG, 1, 32'h0, 0, 0)); step();
      t = iss(K_REG, 2, 32'h4, 0, 0); t.wbv = 2'b01; t.wbi0 = 8; t.wbd0 = 32'h123; drive(t); step();
      t = nop(); t.rst = 1; t.wbv = 2'b01; t.wbi0 = 9; t.wbd0 = 32'h456; drive(t); step();
      got = sample();
      chk("midrst", 128'(got), 128'(0));
      drive(nop()); step();
      got = sample();
      chk("midrst_after", 128'(got), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
